eth_tx_scheduler: RTL and testbench
===================================

Name: eth_tx_scheduler

Overview:
Sequences and shares the single 10G TX send engine (UDP/ARP frame builder feeding the Avalon-ST TX MAC port) between three frame sources: ARP replies triggered by received ARP requests, user UDP transmissions, and ARP requests the block issues itself to resolve the peer MAC. It owns the learned peer MAC, drives the engine's start/type/opcode/destination inputs, and runs ARP request timeout/retry. It sits between the RX parser and the send engine, in the top-level Ethernet wrapper, and replaces ad-hoc ARP glue.

Parameters:
MAC_TYPE_IP, 16'h0800, EtherType driven for UDP frames
MAC_TYPE_ARP, 16'h0806, EtherType driven for ARP frames
ARP_TIMEOUT, 156250, cycles to wait for an ARP reply (1 ms at 156.25 MHz); >=2
ARP_RETRY, 3, total ARP request attempts before failing; >=1

Ports:
clk_156_25  in  1  PHY/MAC clock, 156.25 MHz
rst  in  1  synchronous, active-high reset
arp_reply_req  in  1  1-cycle pulse: an ARP request for our IP was received
arp_peer_mac  in  48  requester MAC, valid with arp_reply_req
rx_arp_valid  in  1  1-cycle pulse: an ARP reply/request from the peer was parsed
rx_arp_mac  in  48  sender MAC, valid with rx_arp_valid
udp_req  in  1  1-cycle pulse: user requests one UDP frame
udp_done  out  1  1-cycle pulse: UDP frame fully handed to the engine
udp_err  out  1  1-cycle pulse: UDP request dropped, peer unresolved after ARP_RETRY attempts
tx_idle  out  1  scheduler idle, nothing pending
peer_resolved  out  1  peer MAC is known
eng_tx_start  out  1  start request to the send engine
eng_tx_idle  in  1  engine idle status
eng_mac_type  out  16  EtherType for the current frame
eng_arp_op  out  1  1 = ARP reply, 0 = ARP request
eng_mac_dst_addr  out  48  destination MAC for the current frame

Behaviour:
- Reset: state IDLE; all pulses 0; eng_tx_start 0; eng_mac_type MAC_TYPE_IP; eng_arp_op 0; eng_mac_dst_addr 48'hFFFF_FFFF_FFFF; peer MAC 48'hFFFF_FFFF_FFFF; peer_resolved 0; pending flags, retry count and timer 0; tx_idle 1 (combinational from state and flags). Reset mid-frame aborts the sequence. The engine is not reset by this block.
- Pending flags: arp_reply_req sets arp_pend and latches reply_mac; a repeat pulse while pending overwrites reply_mac and keeps a single pending reply. udp_req sets udp_pend; a pulse while udp_pend=1 is ignored.
- Learning: rx_arp_valid loads peer MAC from rx_arp_mac and sets peer_resolved, in any state. It has no effect on a frame already in START/BUSY.
- Frame kinds and outputs, registered and held stable from START entry through BUSY:
  - REPLY: type MAC_TYPE_ARP, op 1, dst reply_mac.
  - AREQ: type MAC_TYPE_ARP, op 0, dst all-ones.
  - UDP: type MAC_TYPE_IP, op 0, dst peer MAC.
- FSM states: IDLE, START, BUSY, WAIT_REPLY.
- IDLE: the first matching rule applies; the chosen kind is latched and the next state is START.
  1. arp_pend: REPLY.
  2. udp_pend and peer_resolved: UDP.
  3. udp_pend and not resolved: AREQ.
- START: eng_tx_start=1. Once eng_tx_idle=0 is sampled, go to BUSY and deassert eng_tx_start on the next cycle. There is no timeout.
- BUSY: on eng_tx_idle=1, behaviour depends on the kind:
  - REPLY: clear arp_pend. Return to WAIT_REPLY if the reply preempted it, otherwise go to IDLE.
  - UDP: clear udp_pend, pulse udp_done, clear the retry count, go to IDLE.
  - AREQ: load timer=ARP_TIMEOUT-1, go to WAIT_REPLY.
- WAIT_REPLY: the timer decrements each cycle.
  - peer_resolved=1: go to IDLE; UDP is then issued next.
  - arp_pend=1: freeze the timer, set the preempt flag, start a REPLY.
  - Timer=0 with retry count < ARP_RETRY-1: increment the retry count, go to IDLE, which reissues AREQ.
  - Timer=0 otherwise: clear udp_pend, pulse udp_err, clear the retry count, go to IDLE.
- Priority: an ARP reply always beats UDP/AREQ at arbitration. It never interrupts a frame already started.
- tx_idle = (state==IDLE) & ~arp_pend & ~udp_pend.

Test Plan:
- Reset, then rx_arp_valid with mac 48'h90E2_BA7D_BF0D, then udp_req. Required: eng_tx_start rises 1 cycle after udp_req; type 16'h0800, dst 48'h90E2_BA7D_BF0D. The engine drops eng_tx_idle, holds it low 20 cycles, then raises it; udp_done pulses once and tx_idle returns to 1.
- Unresolved peer, udp_req. Required: AREQ with type 16'h0806, op 0, dst all-ones. Inject rx_arp_valid 100 cycles later; peer_resolved=1, a UDP frame follows, and udp_done pulses.
- Unresolved peer, ARP_TIMEOUT=50, udp_req, no replies. Required: exactly 3 AREQ frames, spaced by timeout plus frame time; then udp_err pulses once and udp_done never pulses.
- arp_reply_req (mac 48'h0011_2233_4455) in the same cycle as udp_req, peer resolved. Required: REPLY (op 1, dst 48'h0011_2233_4455) first, then UDP.
- In WAIT_REPLY with the timer at 10, pulse arp_reply_req. Required: REPLY sent; return to WAIT_REPLY with the timer still at 10.
- Assert rst during BUSY. Required: next cycle eng_tx_start=0, tx_idle=1, peer_resolved=0, dst all-ones.

Source files
------------

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: arbitrates the single 10G TX send engine between three frame sources.
//   - ARP replies to received ARP requests (highest priority)
//   - user UDP frames, sent to the learned peer MAC
//   - ARP requests issued here to resolve the peer MAC, with timeout and retry
// It owns the learned peer MAC and drives the engine's start/type/opcode/destination inputs.
//
// Ports:
//   clk_156_25, rst            clock and synchronous active-high reset
//   arp_reply_req/arp_peer_mac pulse: answer an ARP request from arp_peer_mac
//   rx_arp_valid/rx_arp_mac    pulse: peer MAC learned from a parsed ARP frame
//   udp_req                    pulse: send one UDP frame
//   udp_done, udp_err          pulse: UDP frame handed over / dropped (peer unresolved)
//   tx_idle, peer_resolved     status
//   eng_tx_start, eng_tx_idle  engine handshake
//   eng_mac_type, eng_arp_op,
//   eng_mac_dst_addr           frame descriptor, held stable for the whole frame
module eth_tx_scheduler #(
  parameter logic [15:0] MAC_TYPE_IP  = 16'h0800,
  parameter logic [15:0] MAC_TYPE_ARP = 16'h0806,
  parameter int unsigned ARP_TIMEOUT  = 156250,
  parameter int unsigned ARP_RETRY    = 3
) (
  input  logic        clk_156_25,
  input  logic        rst,
  input  logic        arp_reply_req,
  input  logic [47:0] arp_peer_mac,
  input  logic        rx_arp_valid,
  input  logic [47:0] rx_arp_mac,
  input  logic        udp_req,
  output logic        udp_done,
  output logic        udp_err,
  output logic        tx_idle,
  output logic        peer_resolved,
  output logic        eng_tx_start,
  input  logic        eng_tx_idle,
  output logic [15:0] eng_mac_type,
  output logic        eng_arp_op,
  output logic [47:0] eng_mac_dst_addr
);

  localparam int unsigned TimerW = $clog2(ARP_TIMEOUT);
  localparam int unsigned RetryW = $clog2(ARP_RETRY + 1);
  localparam logic [TimerW-1:0] TimerInit = TimerW'(ARP_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(ARP_RETRY - 1);
  localparam logic [47:0] MacBcast = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StWaitReply} state_e;
  typedef enum logic [1:0] {KindReply, KindAreq, KindUdp} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        arp_pend_q, arp_pend_d;
  logic [47:0] reply_mac_q, reply_mac_d;
  logic        udp_pend_q, udp_pend_d;
  logic [47:0] peer_mac_q, peer_mac_d;
  logic        peer_resolved_q, peer_resolved_d;
  logic        preempt_q, preempt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic        start_q, start_d;
  logic [15:0] mac_type_q, mac_type_d;
  logic        arp_op_q, arp_op_d;
  logic [47:0] dst_q, dst_d;
  logic        udp_done_q, udp_done_d;
  logic        udp_err_q, udp_err_d;

  // Request pulses take part in arbitration in the cycle they arrive.
  logic        arp_pend_now, udp_pend_now;
  logic [47:0] reply_mac_now;
  logic        launch;
  kind_e       launch_kind;

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    arp_pend_d      = arp_pend_q;
    reply_mac_d     = reply_mac_q;
    udp_pend_d      = udp_pend_q;
    peer_mac_d      = peer_mac_q;
    peer_resolved_d = peer_resolved_q;
    preempt_d       = preempt_q;
    retry_d         = retry_q;
    timer_d         = timer_q;
    start_d         = start_q;
    mac_type_d      = mac_type_q;
    arp_op_d        = arp_op_q;
    dst_d           = dst_q;
    udp_done_d      = 1'b0;
    udp_err_d       = 1'b0;
    launch          = 1'b0;
    launch_kind     = KindReply;

    arp_pend_now  = arp_pend_q | arp_reply_req;
    udp_pend_now  = udp_pend_q | udp_req;
    reply_mac_now = arp_reply_req ? arp_peer_mac : reply_mac_q;

    if (arp_reply_req) begin
      arp_pend_d  = 1'b1;
      reply_mac_d = arp_peer_mac;
    end
    if (udp_req) begin
      udp_pend_d = 1'b1;
    end
    if (rx_arp_valid) begin
      peer_mac_d      = rx_arp_mac;
      peer_resolved_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (arp_pend_now) begin
          launch      = 1'b1;
          launch_kind = KindReply;
        end else if (udp_pend_now && peer_resolved_q) begin
          launch      = 1'b1;
          launch_kind = KindUdp;
        end else if (udp_pend_now) begin
          launch      = 1'b1;
          launch_kind = KindAreq;
        end
      end
      StStart: begin
        if (!eng_tx_idle) begin
          state_d = StBusy;
          start_d = 1'b0;
        end
      end
      StBusy: begin
        if (eng_tx_idle) begin
          unique case (kind_q)
            KindReply: begin
              // A new request arriving right now must still get its own reply.
              if (!arp_reply_req) arp_pend_d = 1'b0;
              state_d   = preempt_q ? StWaitReply : StIdle;
              preempt_d = 1'b0;
            end
            KindUdp: begin
              udp_pend_d = 1'b0;
              udp_done_d = 1'b1;
              retry_d    = '0;
              state_d    = StIdle;
            end
            KindAreq: begin
              timer_d = TimerInit;
              state_d = StWaitReply;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StWaitReply: begin
        if (peer_resolved_q) begin
          state_d = StIdle;
        end else if (arp_pend_now) begin
          // Timer is frozen while the reply is out; resume waiting afterwards.
          preempt_d   = 1'b1;
          launch      = 1'b1;
          launch_kind = KindReply;
        end else if (timer_q == '0) begin
          state_d = StIdle;
          if (retry_q < RetryLast) begin
            retry_d = retry_q + RetryW'(1);
          end else begin
            udp_pend_d = 1'b0;
            udp_err_d  = 1'b1;
            retry_d    = '0;
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d = StStart;
      start_d = 1'b1;
      kind_d  = launch_kind;
      unique case (launch_kind)
        KindReply: begin
          mac_type_d = MAC_TYPE_ARP;
          arp_op_d   = 1'b1;
          dst_d      = reply_mac_now;
        end
        KindAreq: begin
          mac_type_d = MAC_TYPE_ARP;
          arp_op_d   = 1'b0;
          dst_d      = MacBcast;
        end
        default: begin
          mac_type_d = MAC_TYPE_IP;
          arp_op_d   = 1'b0;
          dst_d      = peer_mac_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      state_q         <= StIdle;
      kind_q          <= KindReply;
      arp_pend_q      <= 1'b0;
      reply_mac_q     <= '0;
      udp_pend_q      <= 1'b0;
      peer_mac_q      <= MacBcast;
      peer_resolved_q <= 1'b0;
      preempt_q       <= 1'b0;
      retry_q         <= '0;
      timer_q         <= '0;
      start_q         <= 1'b0;
      mac_type_q      <= MAC_TYPE_IP;
      arp_op_q        <= 1'b0;
      dst_q           <= MacBcast;
      udp_done_q      <= 1'b0;
      udp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      arp_pend_q      <= arp_pend_d;
      reply_mac_q     <= reply_mac_d;
      udp_pend_q      <= udp_pend_d;
      peer_mac_q      <= peer_mac_d;
      peer_resolved_q <= peer_resolved_d;
      preempt_q       <= preempt_d;
      retry_q         <= retry_d;
      timer_q         <= timer_d;
      start_q         <= start_d;
      mac_type_q      <= mac_type_d;
      arp_op_q        <= arp_op_d;
      dst_q           <= dst_d;
      udp_done_q      <= udp_done_d;
      udp_err_q       <= udp_err_d;
    end
  end

  assign udp_done         = udp_done_q;
  assign udp_err          = udp_err_q;
  assign tx_idle          = (state_q == StIdle) & ~arp_pend_q & ~udp_pend_q;
  assign peer_resolved    = peer_resolved_q;
  assign eng_tx_start     = start_q;
  assign eng_mac_type     = mac_type_q;
  assign eng_arp_op       = arp_op_q;
  assign eng_mac_dst_addr = dst_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Bench for eth_tx_scheduler: a behavioural send engine captures every started frame and
// compares it with the next expected frame queued by the stimulus.
module tb_eth_tx_scheduler;

  localparam int unsigned Timeout  = 50;
  localparam int unsigned Retry    = 3;
  localparam int unsigned FrameLow = 20;
  localparam logic [47:0] Bcast    = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MacA     = 48'h90E2_BA7D_BF0D;
  localparam logic [47:0] MacB     = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] MacReq   = 48'h0011_2233_4455;
  localparam logic [47:0] MacReq2  = 48'h0066_7788_99AA;

  typedef logic [64:0] frame_t;  // {type, op, dst}

  logic        clk;
  logic        rst;
  logic        arp_reply_req;
  logic [47:0] arp_peer_mac;
  logic        rx_arp_valid;
  logic [47:0] rx_arp_mac;
  logic        udp_req;
  logic        udp_done;
  logic        udp_err;
  logic        tx_idle;
  logic        peer_resolved;
  logic        eng_tx_start;
  logic        eng_tx_idle;
  logic [15:0] eng_mac_type;
  logic        eng_arp_op;
  logic [47:0] eng_mac_dst_addr;

  eth_tx_scheduler #(
    .MAC_TYPE_IP (16'h0800),
    .MAC_TYPE_ARP(16'h0806),
    .ARP_TIMEOUT (Timeout),
    .ARP_RETRY   (Retry)
  ) dut (
    .clk_156_25      (clk),
    .rst             (rst),
    .arp_reply_req   (arp_reply_req),
    .arp_peer_mac    (arp_peer_mac),
    .rx_arp_valid    (rx_arp_valid),
    .rx_arp_mac      (rx_arp_mac),
    .udp_req         (udp_req),
    .udp_done        (udp_done),
    .udp_err         (udp_err),
    .tx_idle         (tx_idle),
    .peer_resolved   (peer_resolved),
    .eng_tx_start    (eng_tx_start),
    .eng_tx_idle     (eng_tx_idle),
    .eng_mac_type    (eng_mac_type),
    .eng_arp_op      (eng_arp_op),
    .eng_mac_dst_addr(eng_mac_dst_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_checks;
  int     n_errors;
  int     done_cnt;
  int     err_cnt;
  int     frames_seen;
  int     cyc;
  int     starts[$];
  frame_t exp_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] t, input logic op, input logic [47:0] dst);
    return {t, op, dst};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (udp_done) done_cnt = done_cnt + 1;
    if (udp_err) err_cnt = err_cnt + 1;
  end

  // Engine model: accepts a start, stays busy FrameLow cycles, checks the descriptor held still.
  initial begin
    frame_t obs;
    frame_t exp;
    logic   aborted;
    eng_tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (eng_tx_start && eng_tx_idle) begin
        obs = {eng_mac_type, eng_arp_op, eng_mac_dst_addr};
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = '1;  // no frame expected: impossible descriptor
        check("frame", obs, exp);
        frames_seen = frames_seen + 1;
        starts.push_back(cyc);
        eng_tx_idle = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < FrameLow; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) check("frame_hold", {eng_mac_type, eng_arp_op, eng_mac_dst_addr}, obs);
        eng_tx_idle = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_resolved", peer_resolved, 1'b0);
    check("rst_start", eng_tx_start, 1'b0);
    check("rst_type", eng_mac_type, 16'h0800);
    check("rst_op", eng_arp_op, 1'b0);
    check("rst_dst", eng_mac_dst_addr, Bcast);
    check("rst_pulses", {udp_done, udp_err}, 2'b00);
  endtask

  task automatic learn(input logic [47:0] mac);
    rx_arp_mac   = mac;
    rx_arp_valid = 1'b1;
    @(negedge clk);
    rx_arp_valid = 1'b0;
    check("learn_resolved", peer_resolved, 1'b1);
  endtask

  task automatic pulse_udp();
    udp_req = 1'b1;
    @(negedge clk);
    udp_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (tx_idle && eng_tx_idle) break;
      @(negedge clk);
    end
    check(tag, {tx_idle, eng_tx_idle}, 2'b11);
  endtask

  initial begin
    int d0, e0, f0, s0, c0;
    n_checks = 0; n_errors = 0; done_cnt = 0; err_cnt = 0; frames_seen = 0; cyc = 0;
    rst = 1'b1; arp_reply_req = 1'b0; arp_peer_mac = '0; rx_arp_valid = 1'b0;
    rx_arp_mac = '0; udp_req = 1'b0;
    @(negedge clk);

    // Resolved peer: UDP start one cycle after the request, then one done pulse.
    do_reset();
    learn(MacA);
    d0 = done_cnt;
    exp_q.push_back(mk(16'h0800, 1'b0, MacA));
    check("udp_start_before", eng_tx_start, 1'b0);
    udp_req = 1'b1;
    @(negedge clk);
    udp_req = 1'b0;
    check("udp_start_latency", eng_tx_start, 1'b1);
    wait_idle(60, "udp_complete");
    repeat (3) @(negedge clk);
    check("udp_done_once", done_cnt - d0, 1);

    // Simultaneous ARP request and UDP request: reply goes out first.
    d0 = done_cnt;
    exp_q.push_back(mk(16'h0806, 1'b1, MacReq));
    exp_q.push_back(mk(16'h0800, 1'b0, MacA));
    arp_peer_mac = MacReq;
    arp_reply_req = 1'b1;
    udp_req = 1'b1;
    @(negedge clk);
    arp_reply_req = 1'b0;
    udp_req = 1'b0;
    wait_idle(120, "reply_udp_complete");
    repeat (3) @(negedge clk);
    check("reply_udp_done", done_cnt - d0, 1);

    // Reset in BUSY aborts the frame and forgets the peer.
    d0 = done_cnt;
    exp_q.push_back(mk(16'h0800, 1'b0, MacA));
    pulse_udp();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_start", eng_tx_start, 1'b0);
    check("abort_tx_idle", tx_idle, 1'b1);
    check("abort_resolved", peer_resolved, 1'b0);
    check("abort_dst", eng_mac_dst_addr, Bcast);
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Unresolved peer, reply learned 100 cycles after the request. With a 50-cycle timeout
    // the first AREQ has timed out by then, so a second AREQ is in flight before the UDP.
    do_reset();
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(mk(16'h0806, 1'b0, Bcast));
    exp_q.push_back(mk(16'h0806, 1'b0, Bcast));
    exp_q.push_back(mk(16'h0800, 1'b0, MacB));
    pulse_udp();
    repeat (99) @(negedge clk);
    learn(MacB);
    wait_idle(200, "resolve_complete");
    repeat (3) @(negedge clk);
    check("resolve_done", done_cnt - d0, 1);
    check("resolve_no_err", err_cnt - e0, 0);

    // No replies: three AREQs, each spaced START(1) + busy(20) + timer(50) + IDLE(1) = 72.
    do_reset();
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = frames_seen;
    s0 = starts.size();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(16'h0806, 1'b0, Bcast));
    pulse_udp();
    wait_idle(400, "retry_complete");
    repeat (10) @(negedge clk);
    check("retry_frames", frames_seen - f0, 3);
    check("retry_err_once", err_cnt - e0, 1);
    check("retry_no_done", done_cnt - d0, 0);
    if (starts.size() >= s0 + 3) begin
      check("retry_gap1", starts[s0+1] - starts[s0], Timeout + 22);
      check("retry_gap2", starts[s0+2] - starts[s0+1], Timeout + 22);
    end

    // Reply preempts WAIT_REPLY at timer 10; the wait resumes from 10, so the next AREQ
    // starts 10 decrements + IDLE + START = 12 cycles after the reply ends.
    do_reset();
    f0 = frames_seen;
    exp_q.push_back(mk(16'h0806, 1'b0, Bcast));
    pulse_udp();
    for (int i = 0; i < 200; i++) begin
      if (dut.timer_q == 6'd10) break;
      @(negedge clk);
    end
    check("preempt_timer_reached", dut.timer_q, 10);
    exp_q.push_back(mk(16'h0806, 1'b1, MacReq2));
    arp_peer_mac = MacReq2;
    arp_reply_req = 1'b1;
    @(negedge clk);
    arp_reply_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (frames_seen >= f0 + 2 && eng_tx_idle) break;
    end
    #1;
    c0 = cyc;
    check("preempt_timer_kept", dut.timer_q, 10);
    exp_q.push_back(mk(16'h0806, 1'b0, Bcast));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frames_seen >= f0 + 3) break;
    end
    check("preempt_frames", frames_seen - f0, 3);
    if (starts.size() > 0) check("preempt_gap", starts[starts.size()-1] - c0, 12);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
